// File: rtl/axi_lite_regfile_slave_if.sv
// AXI-lite bus bundle between the SoC master and the register-file responder.
// Covers all five channels; clock and reset are carried separately.
interface axi_lite_regfile_slave_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic              wvalid;
  logic              wready;
  logic [DATA_W-1:0] wdata;
  logic              bvalid;
  logic              bready;
  logic [1:0]        bresp;
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axi_lite_regfile_slave.sv
// AXI-lite responder holding NUM_REGS control registers, exported flat with per-register
// write pulses. Unmapped accesses complete with SLVERR.
module axi_lite_regfile_slave #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       NUM_REGS  = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [DATA_W-1:0] REG_RESET = '0
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  axi_lite_regfile_slave_if.slave      axi_io,
  output logic [NUM_REGS*DATA_W-1:0]   reg_out_o,
  output logic [NUM_REGS-1:0]          wr_pulse_o
);

  localparam int unsigned LSB   = $clog2(DATA_W / 8);
  localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  logic              aw_held_q, aw_held_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic              w_held_q, w_held_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;

  logic              aw_hs, w_hs, ar_hs, commit;
  logic [ADDR_W-1:0] wr_word, rd_word;
  logic              wr_hit, rd_hit;
  logic [IDX_W-1:0]  wr_idx, rd_idx;

  // Readies are forced low while reset is asserted, not just after the first edge.
  assign axi_io.awready = ~aw_held_q & ~reset_i;
  assign axi_io.wready  = ~w_held_q & ~reset_i;
  assign axi_io.arready = (~rvalid_q | axi_io.rready) & ~reset_i;
  assign axi_io.bvalid  = bvalid_q;
  assign axi_io.bresp   = bresp_q;
  assign axi_io.rvalid  = rvalid_q;
  assign axi_io.rdata   = rdata_q;
  assign axi_io.rresp   = rresp_q;
  assign wr_pulse_o     = wr_pulse_q;

  assign aw_hs  = axi_io.awvalid & axi_io.awready;
  assign w_hs   = axi_io.wvalid & axi_io.wready;
  assign ar_hs  = axi_io.arvalid & axi_io.arready;
  assign commit = aw_held_q & w_held_q & (~bvalid_q | axi_io.bready);

  assign wr_word = (awaddr_q - BASE_ADDR) >> LSB;
  assign rd_word = (axi_io.araddr - BASE_ADDR) >> LSB;
  assign wr_hit  = (awaddr_q >= BASE_ADDR) && (wr_word < ADDR_W'(NUM_REGS));
  assign rd_hit  = (axi_io.araddr >= BASE_ADDR) && (rd_word < ADDR_W'(NUM_REGS));
  assign wr_idx  = wr_word[IDX_W-1:0];
  assign rd_idx  = rd_word[IDX_W-1:0];

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      reg_out_o[i*DATA_W +: DATA_W] = regs_q[i];
    end
  end

  // Write channel: independent AW/W capture, commit once both held and B slot is free.
  always_comb begin
    aw_held_d  = aw_held_q;
    awaddr_d   = awaddr_q;
    w_held_d   = w_held_q;
    wdata_d    = wdata_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    wr_pulse_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end

    if (bvalid_q && axi_io.bready) begin
      bvalid_d = 1'b0;
    end

    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      if (wr_hit) begin
        regs_d[wr_idx]     = wdata_q;
        wr_pulse_d[wr_idx] = 1'b1;
        bresp_d            = RespOkay;
      end else begin
        bresp_d = RespSlverr;
      end
    end else begin
      if (aw_hs) begin
        aw_held_d = 1'b1;
        awaddr_d  = axi_io.awaddr;
      end
      if (w_hs) begin
        w_held_d = 1'b1;
        wdata_d  = axi_io.wdata;
      end
    end
  end

  // Read channel: regs_q is sampled pre-commit, so a same-edge write is not visible.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (rvalid_q && axi_io.rready) begin
      rvalid_d = 1'b0;
    end
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_hit ? regs_q[rd_idx] : '0;
      rresp_d  = rd_hit ? RespOkay : RespSlverr;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      aw_held_q  <= 1'b0;
      awaddr_q   <= '0;
      w_held_q   <= 1'b0;
      wdata_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RespOkay;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RespOkay;
      wr_pulse_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= REG_RESET;
      end
    end else begin
      aw_held_q  <= aw_held_d;
      awaddr_q   <= awaddr_d;
      w_held_q   <= w_held_d;
      wdata_q    <= wdata_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      wr_pulse_q <= wr_pulse_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_regfile_slave.sv
// Directed bench for axi_lite_regfile_slave: a transaction-level model is checked against the
// DUT every cycle, plus literal checks at key points of each scenario.
module tb_axi_lite_regfile_slave;
  localparam int unsigned NREG = 8;
  localparam logic [31:0] BASE = 32'h0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NREG*32-1:0] reg_out;
  logic [NREG-1:0]    wr_pulse;

  int total = 0;
  int bad   = 0;

  axi_lite_regfile_slave_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  axi_lite_regfile_slave #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .NUM_REGS (NREG),
    .BASE_ADDR(BASE),
    .REG_RESET(32'h0)
  ) dut (
    .clk_i     (clk),
    .reset_i   (rst),
    .axi_io    (bus.slave),
    .reg_out_o (reg_out),
    .wr_pulse_o(wr_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: pending-transaction flags plus a register array.
  bit          m_aw_full, m_w_full, m_b_pend, m_r_pend;
  logic [31:0] m_aw_addr, m_w_data, m_rdata;
  logic [1:0]  m_bresp, m_rresp;
  logic [31:0] m_regs [NREG];
  logic [31:0] m_regs_old [NREG];
  logic [NREG-1:0] m_pulse;

  function automatic bit mapped(input logic [31:0] a);
    return (a >= BASE) && ((a - BASE) / 4 < NREG);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_aw_full = 0; m_w_full = 0; m_b_pend = 0; m_r_pend = 0;
      m_bresp = 2'b00; m_rresp = 2'b00; m_rdata = '0; m_pulse = '0;
      for (int i = 0; i < NREG; i++) m_regs[i] = 32'h0;
    end else begin
      bit can_aw, can_w, can_ar, do_commit;
      can_aw = !m_aw_full;
      can_w  = !m_w_full;
      can_ar = !m_r_pend || bus.rready;
      do_commit = m_aw_full && m_w_full && (!m_b_pend || bus.bready);
      for (int i = 0; i < NREG; i++) m_regs_old[i] = m_regs[i];
      m_pulse = '0;
      if (m_b_pend && bus.bready) m_b_pend = 0;
      if (do_commit) begin
        if (mapped(m_aw_addr)) begin
          m_regs[(m_aw_addr - BASE) / 4] = m_w_data;
          m_pulse[(m_aw_addr - BASE) / 4] = 1'b1;
          m_bresp = 2'b00;
        end else begin
          m_bresp = 2'b10;
        end
        m_b_pend = 1; m_aw_full = 0; m_w_full = 0;
      end else begin
        if (bus.awvalid && can_aw) begin m_aw_full = 1; m_aw_addr = bus.awaddr; end
        if (bus.wvalid && can_w) begin m_w_full = 1; m_w_data = bus.wdata; end
      end
      if (m_r_pend && bus.rready) m_r_pend = 0;
      if (bus.arvalid && can_ar) begin
        m_r_pend = 1;
        m_rdata  = mapped(bus.araddr) ? m_regs_old[(bus.araddr - BASE) / 4] : 32'h0;
        m_rresp  = mapped(bus.araddr) ? 2'b00 : 2'b10;
      end
    end
  end

  always @(negedge clk) begin
    logic [NREG*32-1:0] exp_out;
    for (int i = 0; i < NREG; i++) exp_out[i*32 +: 32] = m_regs[i];
    if (rst) begin
      chk("rst_awready", bus.awready, 0);
      chk("rst_wready", bus.wready, 0);
      chk("rst_arready", bus.arready, 0);
      chk("rst_bvalid", bus.bvalid, 0);
      chk("rst_rvalid", bus.rvalid, 0);
      chk("rst_bresp", bus.bresp, 0);
      chk("rst_rresp", bus.rresp, 0);
      chk("rst_rdata", bus.rdata, 0);
      chk("rst_wr_pulse", wr_pulse, 0);
      chk("rst_reg_out", reg_out, 0);
    end else begin
      chk("awready", bus.awready, !m_aw_full);
      chk("wready", bus.wready, !m_w_full);
      chk("arready", bus.arready, !m_r_pend || bus.rready);
      chk("bvalid", bus.bvalid, m_b_pend);
      if (m_b_pend) chk("bresp", bus.bresp, m_bresp);
      chk("rvalid", bus.rvalid, m_r_pend);
      if (m_r_pend) begin
        chk("rdata", bus.rdata, m_rdata);
        chk("rresp", bus.rresp, m_rresp);
      end
      chk("reg_out", reg_out, exp_out);
      chk("wr_pulse", wr_pulse, m_pulse);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wr(input bit aw, input logic [31:0] a, input bit w, input logic [31:0] d);
    bus.awvalid = aw; bus.awaddr = a;
    bus.wvalid  = w;  bus.wdata  = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive_wr(0, 0, 0, 0);
    bus.bready = 1; bus.arvalid = 0; bus.araddr = 0; bus.rready = 1;
    repeat (3) tick();
    rst = 0;
    tick();

    // Same-cycle AW+W to reg 2
    drive_wr(1, 32'h08, 1, 32'hDEAD_BEEF);
    tick();
    drive_wr(0, 0, 0, 0);
    chk("s1_no_early_b", bus.bvalid, 0);
    tick();
    chk("s1_bvalid", bus.bvalid, 1);
    chk("s1_bresp", bus.bresp, 2'b00);
    chk("s1_reg2", reg_out[95:64], 32'hDEAD_BEEF);
    chk("s1_pulse", wr_pulse, 8'b0000_0100);
    tick();
    chk("s1_pulse_gone", wr_pulse, 0);
    chk("s1_b_done", bus.bvalid, 0);

    // W three cycles ahead of AW
    drive_wr(0, 0, 1, 32'h5);
    tick();
    drive_wr(0, 0, 0, 0);
    chk("s2_wready_low", bus.wready, 0);
    tick(); tick();
    drive_wr(1, 32'h1C, 0, 0);
    tick();
    drive_wr(0, 0, 0, 0);
    chk("s2_no_commit_yet", bus.bvalid, 0);
    tick();
    chk("s2_bvalid", bus.bvalid, 1);
    chk("s2_bresp", bus.bresp, 2'b00);
    chk("s2_reg7", reg_out[255:224], 32'h5);
    chk("s2_pulse", wr_pulse, 8'h80);
    tick();

    // Unmapped write and read
    drive_wr(1, 32'h20, 1, 32'h1234);
    bus.arvalid = 1; bus.araddr = 32'h40;
    tick();
    drive_wr(0, 0, 0, 0);
    bus.arvalid = 0;
    chk("s3_rvalid", bus.rvalid, 1);
    chk("s3_rresp", bus.rresp, 2'b10);
    chk("s3_rdata", bus.rdata, 0);
    tick();
    chk("s3_bresp", bus.bresp, 2'b10);
    chk("s3_pulse", wr_pulse, 0);
    chk("s3_reg2_kept", reg_out[95:64], 32'hDEAD_BEEF);
    tick();

    // Backpressure on B with a second write queued
    bus.bready = 0;
    drive_wr(1, 32'h20, 1, 32'h99);
    tick();
    drive_wr(0, 0, 0, 0);
    tick();
    chk("s4_b1", bus.bvalid, 1);
    chk("s4_b1_resp", bus.bresp, 2'b10);
    drive_wr(1, 32'h0C, 1, 32'h33);
    tick();
    drive_wr(0, 0, 0, 0);
    chk("s4_aw_held", bus.awready, 0);
    tick();
    chk("s4_stall_resp", bus.bresp, 2'b10);
    chk("s4_reg3_unwritten", reg_out[127:96], 0);
    tick(); tick();
    bus.bready = 1;
    tick();
    chk("s4_b2", bus.bvalid, 1);
    chk("s4_b2_resp", bus.bresp, 2'b00);
    chk("s4_reg3", reg_out[127:96], 32'h33);
    chk("s4_pulse", wr_pulse, 8'h08);
    tick();
    chk("s4_b_done", bus.bvalid, 0);

    // Read reg 2 on the same edge it is rewritten, then stream reads
    drive_wr(1, 32'h08, 1, 32'h1);
    tick();
    drive_wr(0, 0, 0, 0);
    bus.arvalid = 1; bus.araddr = 32'h08;
    tick();
    chk("s5_old_value", bus.rdata, 32'hDEAD_BEEF);
    chk("s5_reg2_new", reg_out[95:64], 32'h1);
    tick();
    chk("s5_new_value", bus.rdata, 32'h1);
    bus.araddr = 32'h1C;
    tick();
    chk("s5_stream_r7", bus.rdata, 32'h5);
    bus.araddr = 32'h0C;
    tick();
    chk("s5_stream_r3", bus.rdata, 32'h33);
    bus.araddr = 32'h04;
    tick();
    chk("s5_stream_r1", bus.rdata, 32'h0);
    chk("s5_stream_rvalid", bus.rvalid, 1);
    bus.arvalid = 0;
    tick();
    chk("s5_r_done", bus.rvalid, 0);

    // Reset with a pending B and a held W
    bus.bready = 0;
    drive_wr(1, 32'h00, 1, 32'hAA);
    tick();
    drive_wr(0, 0, 0, 0);
    tick();
    chk("s6_reg0", reg_out[31:0], 32'hAA);
    drive_wr(0, 0, 1, 32'h77);
    tick();
    drive_wr(0, 0, 0, 0);
    chk("s6_w_held", bus.wready, 0);
    rst = 1;
    #1;
    chk("s6_bvalid_cleared", bus.bvalid, 0);
    chk("s6_regs_reset", reg_out, 0);
    tick(); tick();
    rst = 0;
    tick();
    chk("s6_no_stale_b", bus.bvalid, 0);
    chk("s6_wready_back", bus.wready, 1);
    drive_wr(1, 32'h00, 0, 0);
    tick();
    drive_wr(0, 0, 0, 0);
    tick(); tick();
    chk("s6_no_stale_commit", bus.bvalid, 0);
    chk("s6_reg0_clear", reg_out[31:0], 0);
    drive_wr(0, 0, 1, 32'h5A);
    tick();
    drive_wr(0, 0, 0, 0);
    tick();
    chk("s6_fresh_commit", reg_out[31:0], 32'h5A);
    bus.bready = 1;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
